// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants: oversample rate, LCR/LSR bit indices, receiver states
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  localparam int LCR_WLS_LO = 0;
  localparam int LCR_WLS_HI = 1;
  localparam int LCR_STB    = 2;
  localparam int LCR_PEN    = 3;
  localparam int LCR_EPS    = 4;

  localparam int LSR_DR = 0;
  localparam int LSR_OE = 1;
  localparam int LSR_PE = 2;
  localparam int LSR_FE = 3;
  localparam int LSR_BI = 4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Index of the last data bit for a word-length code (00=5 bits .. 11=8 bits).
  function automatic logic [2:0] last_bit_idx(input logic [1:0] wls);
    return 3'd4 + {1'b0, wls};
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line, resets to idle (1)
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x oversampling UART receiver; break detection under UART_RX_BREAK_DETECT_EN
module uart_receiver
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       bclk,
  input  logic       rx,
  input  logic [7:0] LCR,
  input  logic       rd,
  output logic [7:0] dout,
  output logic [4:0] LSR
);

  logic       rx_s;
  rx_state_t  state, state_n;
  logic [3:0] tick;
  logic [2:0] bit_cnt;
  logic       stop_cnt;
  logic [7:0] shift;
  logic       par_acc, par_bit, fe_acc;
  logic [4:0] lcr_q;
  logic       dr, oe, pe, fe, bi;
  logic       brk_hold, brk_frame;
  logic       at_mid, at_last, last_data, last_stop, pe_calc;
  logic       start_frame, take_data, take_par, take_stop, frame_done;
  logic [2:0] unused_lcr;

  assign unused_lcr = LCR[7:5];

  uart_rx_sync u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign at_mid    = bclk && (tick == TICK_MID);
  assign at_last   = bclk && (tick == TICK_LAST);
  assign last_data = (bit_cnt == last_bit_idx(lcr_q[LCR_WLS_HI:LCR_WLS_LO]));
  assign last_stop = stop_cnt || !lcr_q[LCR_STB];
  // Even mode wants an even count of ones including the parity bit, odd mode an odd count.
  assign pe_calc   = lcr_q[LCR_PEN] & ~(par_acc ^ par_bit ^ lcr_q[LCR_EPS]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RX_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RX_IDLE:   if (bclk && !rx_s && !brk_hold) state_n = RX_START;
      RX_START:  if (at_mid) state_n = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:   if (at_last && last_data) state_n = lcr_q[LCR_PEN] ? RX_PARITY : RX_STOP;
      RX_PARITY: if (at_last) state_n = RX_STOP;
      RX_STOP:   if (at_last && last_stop) state_n = RX_IDLE;
      default:   state_n = RX_IDLE;
    endcase
  end

  always_comb begin
    start_frame = 1'b0;
    take_data   = 1'b0;
    take_par    = 1'b0;
    take_stop   = 1'b0;
    frame_done  = 1'b0;
    unique case (state)
      RX_IDLE:   start_frame = bclk && !rx_s && !brk_hold;
      RX_DATA:   take_data   = at_last;
      RX_PARITY: take_par    = at_last;
      RX_STOP: begin
        take_stop  = at_last;
        frame_done = at_last && last_stop;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick     <= 4'd0;
      bit_cnt  <= 3'd0;
      stop_cnt <= 1'b0;
      shift    <= 8'h00;
      par_acc  <= 1'b0;
      par_bit  <= 1'b0;
      fe_acc   <= 1'b0;
      lcr_q    <= 5'd0;
    end else begin
      if (state == RX_IDLE) tick <= 4'd0;
      else if (at_mid && state == RX_START) tick <= 4'd0;
      else if (bclk) tick <= tick + 4'd1;

      if (start_frame) begin
        lcr_q    <= LCR[4:0];
        bit_cnt  <= 3'd0;
        stop_cnt <= 1'b0;
        shift    <= 8'h00;
        par_acc  <= 1'b0;
        par_bit  <= 1'b0;
        fe_acc   <= 1'b0;
      end else if (take_data) begin
        shift[bit_cnt] <= rx_s;
        par_acc        <= par_acc ^ rx_s;
        bit_cnt        <= bit_cnt + 3'd1;
      end else if (take_par) begin
        par_bit <= rx_s;
      end else if (take_stop) begin
        fe_acc   <= fe_acc | ~rx_s;
        stop_cnt <= 1'b1;
      end
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic any_one;

  // After a break, start detection stays disarmed until the line returns high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      any_one  <= 1'b0;
      brk_hold <= 1'b0;
    end else begin
      if (start_frame) any_one <= 1'b0;
      else if (take_data || take_par || take_stop) any_one <= any_one | rx_s;

      if (frame_done && brk_frame) brk_hold <= 1'b1;
      else if (rx_s)               brk_hold <= 1'b0;
    end
  end

  assign brk_frame = !any_one && !rx_s;
`else
  assign brk_hold  = 1'b0;
  assign brk_frame = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout <= 8'h00;
      dr   <= 1'b0;
      oe   <= 1'b0;
      pe   <= 1'b0;
      fe   <= 1'b0;
      bi   <= 1'b0;
    end else if (frame_done) begin
      dout <= shift;
      dr   <= 1'b1;
      oe   <= dr & ~rd;
      pe   <= pe_calc;
      fe   <= fe_acc | ~rx_s;
      bi   <= brk_frame;
    end else if (rd && dr) begin
      dr <= 1'b0;
      oe <= 1'b0;
      pe <= 1'b0;
      fe <= 1'b0;
      bi <= 1'b0;
    end
  end

  assign LSR[LSR_DR] = dr;
  assign LSR[LSR_OE] = oe;
  assign LSR[LSR_PE] = pe;
  assign LSR[LSR_FE] = fe;
  assign LSR[LSR_BI] = bi;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
module tb_uart_receiver;

  localparam int BIT_CLKS = 64;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       bclk  = 1'b0;
  logic       rx    = 1'b1;
  logic       rd    = 1'b0;
  logic [7:0] LCR   = 8'h03;
  logic [7:0] dout;
  logic [4:0] LSR;

  int checks = 0;
  int errors = 0;
  int bdiv   = 0;

  uart_receiver dut (
    .clk   (clk),
    .reset (reset),
    .bclk  (bclk),
    .rx    (rx),
    .LCR   (LCR),
    .rd    (rd),
    .dout  (dout),
    .LSR   (LSR)
  );

  always #5 clk = ~clk;

  // bclk = one clk in four, so one bit time is 64 clks
  always @(negedge clk) begin
    bdiv = (bdiv + 1) % 4;
    bclk = (bdiv == 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  task automatic send_frame(input logic [7:0] data, input int nbits, input bit par_en,
                            input logic par_val, input logic [1:0] stop_vals, input int nstops,
                            input int rd_at, output int done_k);
    logic [15:0] bits;
    int          idx;
    int          nb;
    bits    = '1;
    bits[0] = 1'b0;
    idx     = 1;
    for (int i = 0; i < nbits; i++) begin
      bits[idx] = data[i];
      idx++;
    end
    if (par_en) begin
      bits[idx] = par_val;
      idx++;
    end
    for (int i = 0; i < nstops; i++) begin
      bits[idx] = stop_vals[i];
      idx++;
    end
    nb     = idx + 1;
    done_k = -1;
    @(negedge clk); #1;
    while (bdiv != 0) begin
      @(negedge clk); #1;
    end
    for (int k = 0; k < nb * BIT_CLKS; k++) begin
      @(negedge clk);
      if (LSR[0] === 1'b1 && done_k < 0) done_k = k;
      rx = bits[k / BIT_CLKS];
      rd = (k == rd_at);
    end
    rd = 1'b0;
  endtask

  task automatic do_read();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected %h", dout, 8'h00); end
    checks++;
    if (LSR !== 5'b00000) begin errors++; $display("FAIL reset_lsr: got %b expected %b", LSR, 5'b00000); end
    reset = 1'b1;
    repeat (200) @(negedge clk);
    checks++;
    if (LSR !== 5'b00000) begin errors++; $display("FAIL reset_idle_lsr: got %b expected %b", LSR, 5'b00000); end
  endtask

  task automatic test_8n1();
    int dk;
    LCR = 8'h03;
    send_frame(8'hA5, 8, 0, 1'b0, 2'b11, 1, -1, dk);
    checks++;
    if (dout !== 8'hA5) begin errors++; $display("FAIL 8n1_dout: got %h expected %h", dout, 8'hA5); end
    checks++;
    if (LSR !== 5'b00001) begin errors++; $display("FAIL 8n1_lsr: got %b expected %b", LSR, 5'b00001); end
    do_read();
    checks++;
    if (LSR !== 5'b00000) begin errors++; $display("FAIL 8n1_rd_lsr: got %b expected %b", LSR, 5'b00000); end
    checks++;
    if (dout !== 8'hA5) begin errors++; $display("FAIL 8n1_rd_dout: got %h expected %h", dout, 8'hA5); end
  endtask

  task automatic test_parity();
    int dk;
    LCR = 8'h1B;
    send_frame(8'h07, 8, 1, 1'b0, 2'b11, 1, -1, dk);
    checks++;
    if (dout !== 8'h07) begin errors++; $display("FAIL even_bad_dout: got %h expected %h", dout, 8'h07); end
    checks++;
    if (LSR !== 5'b00101) begin errors++; $display("FAIL even_bad_lsr: got %b expected %b", LSR, 5'b00101); end
    do_read();
    send_frame(8'h07, 8, 1, 1'b1, 2'b11, 1, -1, dk);
    checks++;
    if (LSR !== 5'b00001) begin errors++; $display("FAIL even_good_lsr: got %b expected %b", LSR, 5'b00001); end
    do_read();
    LCR = 8'h0B;
    send_frame(8'h07, 8, 1, 1'b0, 2'b11, 1, -1, dk);
    checks++;
    if (LSR !== 5'b00001) begin errors++; $display("FAIL odd_good_lsr: got %b expected %b", LSR, 5'b00001); end
    do_read();
    send_frame(8'h00, 8, 1, 1'b0, 2'b11, 1, -1, dk);
    checks++;
    if (LSR !== 5'b00101) begin errors++; $display("FAIL odd_bad_lsr: got %b expected %b", LSR, 5'b00101); end
    do_read();
  endtask

  task automatic test_framing_widths();
    int dk;
    LCR = 8'h00;
    send_frame(8'h1F, 5, 0, 1'b0, 2'b00, 1, -1, dk);
    checks++;
    if (dout !== 8'h1F) begin errors++; $display("FAIL 5n1_fe_dout: got %h expected %h", dout, 8'h1F); end
    checks++;
    if (LSR !== 5'b01001) begin errors++; $display("FAIL 5n1_fe_lsr: got %b expected %b", LSR, 5'b01001); end
    do_read();
    LCR = 8'h01;
    send_frame(8'h2A, 6, 0, 1'b0, 2'b11, 1, -1, dk);
    checks++;
    if (dout !== 8'h2A) begin errors++; $display("FAIL 6n1_dout: got %h expected %h", dout, 8'h2A); end
    do_read();
    LCR = 8'h02;
    send_frame(8'hFF, 7, 0, 1'b0, 2'b11, 1, -1, dk);
    checks++;
    if (dout !== 8'h7F) begin errors++; $display("FAIL 7n1_dout: got %h expected %h", dout, 8'h7F); end
    do_read();
    LCR = 8'h07;
    send_frame(8'h3C, 8, 0, 1'b0, 2'b01, 2, -1, dk);
    checks++;
    if (LSR !== 5'b01001) begin errors++; $display("FAIL 8n2_stop2_lsr: got %b expected %b", LSR, 5'b01001); end
    do_read();
    send_frame(8'h3C, 8, 0, 1'b0, 2'b10, 2, -1, dk);
    checks++;
    if (LSR !== 5'b01001) begin errors++; $display("FAIL 8n2_stop1_lsr: got %b expected %b", LSR, 5'b01001); end
    do_read();
    send_frame(8'hC3, 8, 0, 1'b0, 2'b11, 2, -1, dk);
    checks++;
    if (LSR !== 5'b00001 || dout !== 8'hC3) begin
      errors++; $display("FAIL 8n2_good: got lsr %b dout %h expected lsr %b dout %h", LSR, dout, 5'b00001, 8'hC3);
    end
    do_read();
  endtask

  task automatic test_overrun();
    int dk;
    LCR = 8'h03;
    send_frame(8'h11, 8, 0, 1'b0, 2'b11, 1, -1, dk);
    send_frame(8'h22, 8, 0, 1'b0, 2'b11, 1, -1, dk);
    checks++;
    if (dout !== 8'h22) begin errors++; $display("FAIL overrun_dout: got %h expected %h", dout, 8'h22); end
    checks++;
    if (LSR !== 5'b00011) begin errors++; $display("FAIL overrun_lsr: got %b expected %b", LSR, 5'b00011); end
    do_read();
    checks++;
    if (LSR !== 5'b00000) begin errors++; $display("FAIL overrun_rd_lsr: got %b expected %b", LSR, 5'b00000); end
  endtask

  task automatic test_rd_coincident();
    int m;
    int dk;
    LCR = 8'h03;
    send_frame(8'h11, 8, 0, 1'b0, 2'b11, 1, -1, m);
    checks++;
    if (m <= 0) begin
      errors++; $display("FAIL coincide_measure: got done index %0d expected positive", m);
    end else begin
      send_frame(8'h22, 8, 0, 1'b0, 2'b11, 1, m - 1, dk);
      checks++;
      if (dout !== 8'h22) begin errors++; $display("FAIL coincide_dout: got %h expected %h", dout, 8'h22); end
      checks++;
      if (LSR !== 5'b00001) begin errors++; $display("FAIL coincide_lsr: got %b expected %b", LSR, 5'b00001); end
    end
    do_read();
  endtask

  task automatic test_false_start();
    int dk;
    LCR = 8'h03;
    send_frame(8'h5A, 8, 0, 1'b0, 2'b11, 1, -1, dk);
    @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (700) @(negedge clk);
    checks++;
    if (dout !== 8'h5A) begin errors++; $display("FAIL glitch_dout: got %h expected %h", dout, 8'h5A); end
    checks++;
    if (LSR !== 5'b00001) begin errors++; $display("FAIL glitch_lsr: got %b expected %b", LSR, 5'b00001); end
    do_read();
  endtask

  task automatic test_reset_mid_frame();
    int dk;
    LCR = 8'h03;
    send_frame(8'hA5, 8, 0, 1'b0, 2'b11, 1, -1, dk);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (LSR !== 5'b00000 || dout !== 8'h00) begin
      errors++; $display("FAIL midreset_state: got lsr %b dout %h expected lsr %b dout %h", LSR, dout, 5'b00000, 8'h00);
    end
    reset = 1'b1;
    repeat (100) @(negedge clk);
    send_frame(8'h3C, 8, 0, 1'b0, 2'b11, 1, -1, dk);
    checks++;
    if (dout !== 8'h3C) begin errors++; $display("FAIL midreset_next_dout: got %h expected %h", dout, 8'h3C); end
    checks++;
    if (LSR !== 5'b00001) begin errors++; $display("FAIL midreset_next_lsr: got %b expected %b", LSR, 5'b00001); end
    do_read();
  endtask

  task automatic test_break();
    int dk;
    LCR = 8'h03;
    @(negedge clk);
    rx = 1'b0;
    repeat (2 * 10 * BIT_CLKS) @(negedge clk);
`ifdef UART_RX_BREAK_DETECT_EN
    checks++;
    if (LSR !== 5'b11001) begin errors++; $display("FAIL break_lsr: got %b expected %b", LSR, 5'b11001); end
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL break_dout: got %h expected %h", dout, 8'h00); end
    do_read();
    repeat (700) @(negedge clk);
    checks++;
    if (LSR !== 5'b00000) begin errors++; $display("FAIL break_hold_lsr: got %b expected %b", LSR, 5'b00000); end
    rx = 1'b1;
    repeat (100) @(negedge clk);
`else
    checks++;
    if ({LSR[4], LSR[3]} !== 2'b01) begin errors++; $display("FAIL nobreak_bi_fe: got %b expected %b", {LSR[4], LSR[3]}, 2'b01); end
    rx = 1'b1;
    repeat (800) @(negedge clk);
    do_read();
`endif
    checks++;
    if (LSR !== 5'b00000) begin errors++; $display("FAIL break_after_lsr: got %b expected %b", LSR, 5'b00000); end
    send_frame(8'h5A, 8, 0, 1'b0, 2'b11, 1, -1, dk);
    checks++;
    if (dout !== 8'h5A || LSR !== 5'b00001) begin
      errors++; $display("FAIL break_recover: got lsr %b dout %h expected lsr %b dout %h", LSR, dout, 5'b00001, 8'h5A);
    end
    do_read();
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_framing_widths();
    test_overrun();
    test_rd_coincident();
    test_false_start();
    test_reset_mid_frame();
    test_break();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
